serial_pair_transmitter: RTL

SERIAL_PAIR_TRANSMITTER -- requirements
Module: serial_pair_transmitter

---
 rtl/serial_pair_transmitter_pkg.sv | 12 +
 rtl/serial_shift_register.sv | 33 +++
 rtl/serial_pair_transmitter.sv | 74 +++++++
 3 files changed

// File: rtl/serial_pair_transmitter_pkg.sv
// serial_pair_transmitter_pkg: shared FSM state type and bit-order constants
package serial_pair_transmitter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIT_ORDER_LSB = 0;
    localparam int BIT_ORDER_MSB = 1;

endpackage

// File: rtl/serial_shift_register.sv
// serial_shift_register: loadable shift register presenting one bit per shift, MSB- or LSB-first
module serial_shift_register
    import serial_pair_transmitter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    // Load has priority; a shift moves the next bit into the output position.
    always_comb begin
        sr_d = load_i ? data_i
             : shift_i ? ((MSB_FIRST == BIT_ORDER_MSB) ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]})
             : sr_q;
    end

    // Register holding the not-yet-sent bits of the operand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end

    assign bit_o = (MSB_FIRST == BIT_ORDER_MSB) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_pair_transmitter.sv
// serial_pair_transmitter: serialises an operand pair bit-by-bit with valid/ready handshakes
module serial_pair_transmitter
    import serial_pair_transmitter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy, out_xfer, load, bit_a, bit_b;

    assign busy      = (state_q == SHIFT);
    assign out_valid = busy;
    assign out_first = busy & (cnt_q == '0);
    assign out_last  = busy & (cnt_q == LAST);
    assign out_xfer  = out_valid & out_ready;
    assign in_ready  = ~busy | (out_xfer & out_last);
    assign load      = in_valid & in_ready;
    assign out_a     = busy & bit_a;
    assign out_b     = busy & bit_b;

    // Next state: a new load wins, so a word can follow the last bit with no idle cycle.
    always_comb begin
        state_d = load ? SHIFT : (out_xfer & out_last) ? IDLE : state_q;
        cnt_d   = load ? '0 : (out_xfer & ~out_last) ? cnt_q + 1'b1 : cnt_q;
    end

    // Control state: word-held flag and index of the bit being presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_a (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .shift_i(out_xfer & ~out_last),
        .data_i (in_a),
        .bit_o  (bit_a)
    );

    serial_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_b (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .shift_i(out_xfer & ~out_last),
        .data_i (in_b),
        .bit_o  (bit_b)
    );

endmodule
